// File: rtl/arbiter_pkg.sv
// Shared types and constants for the cache-to-memory line arbiter.
package arbiter_pkg;

    localparam int unsigned LINE_W      = 256;
    localparam int unsigned BURST_W     = 64;
    localparam int unsigned BEATS       = LINE_W / BURST_W;
    localparam int unsigned OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/arb_line_adaptor.sv
// Line adaptor: beat counter, line register, beat insert on reads and
// beat extract on writes, plus the last-beat flag that ends a burst.
module arb_line_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned BEATS   = LINE_W / BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_write,
    input  logic               active,
    input  logic [LINE_W-1:0]  wline,
    input  logic               pmem_resp,
    input  logic [BURST_W-1:0] pmem_rdata,
    output logic [LINE_W-1:0]  line,
    output logic [BURST_W-1:0] pmem_wdata,
    output logic               last_beat
);
    import arbiter_pkg::*;

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [LINE_W-1:0] line_q;
    logic              beat_ok;

    // A beat only counts while a burst is on the bus; stray responses are dropped.
    assign beat_ok   = active && pmem_resp;
    assign last_beat = beat_ok && (cnt_q == CNT_W'(BEATS - 1));

    // Beat counter: cleared on a new grant and after the final beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (start || last_beat) begin
            cnt_q <= '0;
        end else if (beat_ok) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Line register: loaded whole for writebacks, filled beat by beat for reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else if (start && is_write) begin
            line_q <= wline;
        end else if (beat_ok && !is_write) begin
            line_q[cnt_q*BURST_W +: BURST_W] <= pmem_rdata;
        end
    end

    // Write beat is selected straight from the counter so it tracks wait states.
    always_comb begin
        pmem_wdata = '0;
        if (active && is_write) begin
            pmem_wdata = line_q[cnt_q*BURST_W +: BURST_W];
        end
    end

    assign line = line_q;

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serialising I-cache and D-cache line fills and
// writebacks onto a single beat-oriented memory burst interface.
module cache_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [LINE_W-1:0]  i_rdata,
    output logic               i_resp,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [LINE_W-1:0]  d_wdata,
    output logic [LINE_W-1:0]  d_rdata,
    output logic               d_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [ADDR_W-1:0]  pmem_address,
    output logic [BURST_W-1:0] pmem_wdata,
    input  logic [BURST_W-1:0] pmem_rdata,
    input  logic               pmem_resp
);
    localparam int unsigned BEATS = LINE_W / BURST_W;

    import arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);

    arb_state_t        state_q, state_d;
    arb_state_t        burst_q, burst_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              i_req, d_req;
    logic              start, is_write, active, last_beat;
    logic [LINE_W-1:0] line;

    assign i_req    = i_read;
    assign d_req    = d_read | d_write;
    assign start    = (state_q == IDLE) && (state_d != IDLE);
    assign active   = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
    // True on the granting edge as well, so the write line is captured at grant.
    assign is_write = (state_q == D_WR) || (state_d == D_WR);

    arb_line_adaptor #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W),
        .BEATS   (BEATS)
    ) u_adaptor (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_write   (is_write),
        .active     (active),
        .wline      (d_wdata),
        .pmem_resp  (pmem_resp),
        .pmem_rdata (pmem_rdata),
        .line       (line),
        .pmem_wdata (pmem_wdata),
        .last_beat  (last_beat)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst context: latched address, which burst is running, round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            burst_q      <= IDLE;
            last_grant_q <= GRANT_D;
        end else begin
            addr_q       <= addr_d;
            burst_q      <= burst_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state and arbitration; the pointer only moves when both caches contend.
    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        addr_d       = addr_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    if (last_grant_q == GRANT_D) begin
                        state_d      = I_RD;
                        addr_d       = i_address & ~OFF_MASK;
                        last_grant_d = GRANT_I;
                    end else begin
                        state_d      = d_write ? D_WR : D_RD;
                        addr_d       = d_address & ~OFF_MASK;
                        last_grant_d = GRANT_D;
                    end
                end else if (d_req) begin
                    state_d = d_write ? D_WR : D_RD;
                    addr_d  = d_address & ~OFF_MASK;
                end else if (i_req) begin
                    state_d = I_RD;
                    addr_d  = i_address & ~OFF_MASK;
                end
                burst_d = state_d;
            end
            I_RD, D_RD, D_WR: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes during the burst, one response pulse to the served cache in DONE.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        unique case (state_q)
            I_RD, D_RD: begin
                pmem_read    = 1'b1;
                pmem_address = addr_q;
            end
            D_WR: begin
                pmem_write   = 1'b1;
                pmem_address = addr_q;
            end
            DONE: begin
                if (burst_q == I_RD) begin
                    i_resp  = 1'b1;
                    i_rdata = line;
                end else if (burst_q == D_RD) begin
                    d_resp  = 1'b1;
                    d_rdata = line;
                end else if (burst_q == D_WR) begin
                    d_resp  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
